// File: rtl/prio_encoder_pipe_pkg.sv
// ---------------------------------------------------------------------------
// encoder_pkg
// Shared types and helpers for the pipelined priority encoder.
//   enc_mode_e : priority selection mode (LSB-first, MSB-first, round-robin)
//   enc_size() : index width for a request vector of w bits, never below 1
// ---------------------------------------------------------------------------
package encoder_pkg;

  typedef enum logic [1:0] {
    ENC_LSB_FIRST   = 2'd0,
    ENC_MSB_FIRST   = 2'd1,
    ENC_ROUND_ROBIN = 2'd2
  } enc_mode_e;

  // max(1, $clog2(w)): a 1-bit request still needs a 1-bit index port.
  function automatic int enc_size(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage : encoder_pkg

// File: rtl/prio_encoder_pipe_if.sv
// ---------------------------------------------------------------------------
// prio_encoder_pipe_if
// Request/result handshake bundle for prio_encoder_pipe.
//   in_valid  : producer -> encoder, in_req is valid
//   in_ready  : encoder -> producer, stage can accept
//   in_req    : producer -> encoder, WIDTH-bit request vector
//   out_valid : encoder -> consumer, result registers hold a result
//   out_ready : consumer -> encoder, result accepted
//   out_idx   : encoder -> consumer, selected index (0 when out_none)
//   out_none  : encoder -> consumer, captured request was all-zero
//   out_multi : encoder -> consumer, captured request had >1 bit set
// Modports: master = producer/consumer side, slave = encoder side.
// ---------------------------------------------------------------------------
interface prio_encoder_pipe_if
  import encoder_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int SIZE = enc_size(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_req;
  logic             out_valid;
  logic             out_ready;
  logic [SIZE-1:0]  out_idx;
  logic             out_none;
  logic             out_multi;

  modport master (
    output in_valid, in_req, out_ready,
    input  in_ready, out_valid, out_idx, out_none, out_multi
  );

  modport slave (
    input  in_valid, in_req, out_ready,
    output in_ready, out_valid, out_idx, out_none, out_multi
  );

endinterface : prio_encoder_pipe_if

// File: rtl/prio_encoder_pipe_enc_prio_lsb.sv
// ---------------------------------------------------------------------------
// enc_prio_lsb
// Combinational lowest-set-bit encoder, the building block for every
// priority mode of prio_encoder_pipe.
//   req_i : WIDTH-bit request vector
//   idx_o : index of the lowest set bit, 0 when no bit is set
//   any_o : at least one bit of req_i is set
// ---------------------------------------------------------------------------
module enc_prio_lsb
  import encoder_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SIZE  = enc_size(WIDTH)
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [SIZE-1:0]  idx_o,
  output logic             any_o
);

  // Scanning from the top down lets the lowest set bit overwrite last.
  always_comb begin
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = SIZE'(i);
      end
    end
  end

  assign any_o = |req_i;

endmodule : enc_prio_lsb

// File: rtl/prio_encoder_pipe.sv
// ---------------------------------------------------------------------------
// prio_encoder_pipe
// Registered, valid/ready handshaked WIDTH-to-SIZE priority encoder for
// multi-hot request vectors. One result register stage, latency 1, full
// throughput. Priority mode chosen by MODE:
//   ENC_LSB_FIRST   : lowest set index
//   ENC_MSB_FIRST   : highest set index
//   ENC_ROUND_ROBIN : lowest set index >= rr_ptr, else lowest overall
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : prio_encoder_pipe_if.slave (in_* request side, out_* result side)
// Build option:
//   ENC_MULTIHOT_CHECK_EN : when defined, out_multi flags captured requests
//                           with more than one bit set; otherwise tied 0.
// ---------------------------------------------------------------------------
module prio_encoder_pipe
  import encoder_pkg::*;
#(
  parameter int        WIDTH = 8,
  parameter enc_mode_e MODE  = ENC_LSB_FIRST
) (
  input  logic               clk,
  input  logic               rst_n,
  prio_encoder_pipe_if.slave bus
);

  localparam int SIZE = enc_size(WIDTH);

  logic [SIZE-1:0] sel_idx;
  logic            sel_any;
  logic            accept;

  logic            out_valid_q;
  logic [SIZE-1:0] out_idx_q;
  logic            out_none_q;

  // The stage frees up in the same cycle the consumer drains it.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // -------------------------------------------------------------------------
  // Index selection per mode
  // -------------------------------------------------------------------------
  generate
    if (MODE == ENC_MSB_FIRST) begin : g_msb
      logic [WIDTH-1:0] req_rev;
      logic [SIZE-1:0]  idx_rev;
      logic             any_rev;

      // Highest set bit of req is the lowest set bit of the mirrored vector.
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
        assign req_rev[gi] = bus.in_req[WIDTH-1-gi];
      end

      enc_prio_lsb #(.WIDTH(WIDTH)) u_enc (
        .req_i (req_rev),
        .idx_o (idx_rev),
        .any_o (any_rev)
      );

      assign sel_any = any_rev;
      assign sel_idx = any_rev ? (SIZE'(WIDTH - 1) - idx_rev) : '0;

    end else if (MODE == ENC_ROUND_ROBIN) begin : g_rr
      logic [SIZE-1:0]  rr_ptr_q;
      logic [SIZE-1:0]  rr_ptr_d;
      logic [WIDTH-1:0] req_mask;
      logic [SIZE-1:0]  idx_mask;
      logic             any_mask;
      logic [SIZE-1:0]  idx_raw;
      logic             any_raw;

      // Keep only requests at or above the pointer.
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
        assign req_mask[gi] = bus.in_req[gi] && (SIZE'(gi) >= rr_ptr_q);
      end

      enc_prio_lsb #(.WIDTH(WIDTH)) u_enc_mask (
        .req_i (req_mask),
        .idx_o (idx_mask),
        .any_o (any_mask)
      );

      enc_prio_lsb #(.WIDTH(WIDTH)) u_enc_raw (
        .req_i (bus.in_req),
        .idx_o (idx_raw),
        .any_o (any_raw)
      );

      // No request at/above the pointer: wrap to the lowest one overall.
      assign sel_any = any_raw;
      assign sel_idx = any_mask ? idx_mask : idx_raw;

      // Wrap at WIDTH rather than 2^SIZE so non-power-of-2 widths rotate cleanly.
      assign rr_ptr_d = (sel_idx == SIZE'(WIDTH - 1)) ? '0 : (sel_idx + 1'b1);

      // An empty request leaves the pointer alone.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rr_ptr_q <= '0;
        end else if (accept && sel_any) begin
          rr_ptr_q <= rr_ptr_d;
        end
      end

    end else begin : g_lsb
      enc_prio_lsb #(.WIDTH(WIDTH)) u_enc (
        .req_i (bus.in_req),
        .idx_o (sel_idx),
        .any_o (sel_any)
      );
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Result register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_none_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_idx_q   <= sel_idx;
      out_none_q  <= !sel_any;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_none  = out_none_q;

`ifdef ENC_MULTIHOT_CHECK_EN
  logic out_multi_q;
  logic multi_d;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_d = |(bus.in_req & (bus.in_req - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_multi_q <= 1'b0;
    end else if (accept) begin
      out_multi_q <= multi_d;
    end
  end

  assign bus.out_multi = out_multi_q;
`else
  assign bus.out_multi = 1'b0;
`endif

`ifndef SYNTHESIS
  // An unknown request would silently pick an arbitrary index downstream.
  a_req_known : assert property (@(posedge clk) disable iff (!rst_n)
    bus.in_valid |-> !$isunknown(bus.in_req))
    else $error("%m: in_req contains X/Z while in_valid is high");
`endif

endmodule : prio_encoder_pipe

// File: tb/tb_prio_encoder_pipe.sv
module tb_prio_encoder_pipe;
  import encoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prio_encoder_pipe_if #(.WIDTH(8)) b0 ();
  prio_encoder_pipe_if #(.WIDTH(8)) b1 ();
  prio_encoder_pipe_if #(.WIDTH(5)) b2 ();

  prio_encoder_pipe #(.WIDTH(8), .MODE(ENC_LSB_FIRST)) dut_lsb (
    .clk (clk), .rst_n (rst_n), .bus (b0)
  );
  prio_encoder_pipe #(.WIDTH(8), .MODE(ENC_MSB_FIRST)) dut_msb (
    .clk (clk), .rst_n (rst_n), .bus (b1)
  );
  prio_encoder_pipe #(.WIDTH(5), .MODE(ENC_ROUND_ROBIN)) dut_rr (
    .clk (clk), .rst_n (rst_n), .bus (b2)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Per-DUT configuration: 0 = LSB W8, 1 = MSB W8, 2 = round-robin W5.
  int W [3] = '{8, 8, 5};
  int MD[3] = '{0, 1, 2};

  // Stimulus for the next cycle.
  bit         iv  [3];
  logic [7:0] rq  [3];
  bit         ordy[3];

  // Reference model state.
  bit m_valid[3];
  int m_idx  [3];
  bit m_none [3];
  bit m_multi[3];
  int m_ptr  [3];

  localparam bit MULTI_EN =
`ifdef ENC_MULTIHOT_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  // Selected index straight from the priority rules.
  function automatic int ref_idx(input logic [7:0] req, input int w, input int md, input int ptr);
    int r = 0;
    bit f = 0;
    if (md == 0) begin
      for (int i = 0; i < w; i++) if (!f && req[i]) begin r = i; f = 1; end
    end else if (md == 1) begin
      for (int i = w - 1; i >= 0; i--) if (!f && req[i]) begin r = i; f = 1; end
    end else begin
      for (int i = ptr; i < w; i++) if (!f && req[i]) begin r = i; f = 1; end
      for (int i = 0; i < w; i++) if (!f && req[i]) begin r = i; f = 1; end
    end
    return r;
  endfunction

  function automatic int popc(input logic [7:0] req, input int w);
    int c = 0;
    for (int i = 0; i < w; i++) c += int'(req[i]);
    return c;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s dut%0d: observed %0d expected %0d", tag, d, obs, exp);
    end
  endtask

  task automatic apply();
    b0.in_valid = iv[0]; b0.in_req = rq[0];      b0.out_ready = ordy[0];
    b1.in_valid = iv[1]; b1.in_req = rq[1];      b1.out_ready = ordy[1];
    b2.in_valid = iv[2]; b2.in_req = rq[2][4:0]; b2.out_ready = ordy[2];
  endtask

  task automatic idle();
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; rq[d] = 8'h00; ordy[d] = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_valid[d] = 0; m_idx[d] = 0; m_none[d] = 0; m_multi[d] = 0; m_ptr[d] = 0;
    end
  endtask

  function automatic logic [31:0] dut_rdy(input int d);
    case (d)
      0:       return 32'(b0.in_ready);
      1:       return 32'(b1.in_ready);
      default: return 32'(b2.in_ready);
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 0, 32'(b0.out_valid), 32'(m_valid[0]));
    chk({tag, ".idx"},   0, 32'(b0.out_idx),   32'(m_idx[0]));
    chk({tag, ".none"},  0, 32'(b0.out_none),  32'(m_none[0]));
    chk({tag, ".multi"}, 0, 32'(b0.out_multi), 32'(m_multi[0]));
    chk({tag, ".valid"}, 1, 32'(b1.out_valid), 32'(m_valid[1]));
    chk({tag, ".idx"},   1, 32'(b1.out_idx),   32'(m_idx[1]));
    chk({tag, ".none"},  1, 32'(b1.out_none),  32'(m_none[1]));
    chk({tag, ".multi"}, 1, 32'(b1.out_multi), 32'(m_multi[1]));
    chk({tag, ".valid"}, 2, 32'(b2.out_valid), 32'(m_valid[2]));
    chk({tag, ".idx"},   2, 32'(b2.out_idx),   32'(m_idx[2]));
    chk({tag, ".none"},  2, 32'(b2.out_none),  32'(m_none[2]));
    chk({tag, ".multi"}, 2, 32'(b2.out_multi), 32'(m_multi[2]));
    chk({tag, ".rr_ptr"}, 2, 32'(dut_rr.g_rr.rr_ptr_q), 32'(m_ptr[2]));
  endtask

  // One clock cycle: drive at the falling edge, check ready before the
  // rising edge, advance the model at the rising edge, check results after.
  task automatic step(input string tag);
    bit rdy[3];
    apply();
    #1;
    for (int d = 0; d < 3; d++) begin
      rdy[d] = !m_valid[d] || ordy[d];
      chk({tag, ".in_ready"}, d, dut_rdy(d), 32'(rdy[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (iv[d] && rdy[d]) begin
        m_valid[d] = 1;
        m_none[d]  = (popc(rq[d], W[d]) == 0);
        m_idx[d]   = ref_idx(rq[d], W[d], MD[d], m_ptr[d]);
        m_multi[d] = MULTI_EN && (popc(rq[d], W[d]) > 1);
        if (MD[d] == 2 && !m_none[d]) m_ptr[d] = (m_idx[d] + 1) % W[d];
      end else if (ordy[d]) begin
        m_valid[d] = 0;
      end
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  int rr_exp_idx[4] = '{0, 1, 4, 0};
  int rr_exp_ptr[4] = '{1, 2, 0, 1};

  initial begin
    idle();
    apply();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    for (int d = 0; d < 3; d++) chk("reset.in_ready", d, dut_rdy(d), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // LSB-first on a multi-hot request.
    idle(); iv[0] = 1; rq[0] = 8'b0110_1000;
    step("lsb");
    chk("lsb_idx3", 0, 32'(b0.out_idx), 32'd3);
    $display("lsb req=%b idx=%0d none=%0d", rq[0], b0.out_idx, b0.out_none);

    // MSB-first, then an empty request.
    idle(); iv[1] = 1; rq[1] = 8'b0110_1000;
    step("msb");
    chk("msb_idx6", 1, 32'(b1.out_idx), 32'd6);
    $display("msb req=%b idx=%0d none=%0d", rq[1], b1.out_idx, b1.out_none);
    rq[1] = 8'h00;
    step("msb_zero");
    chk("msb_zero_none", 1, 32'(b1.out_none), 32'd1);
    chk("msb_zero_idx", 1, 32'(b1.out_idx), 32'd0);
    $display("msb req=%b idx=%0d none=%0d", rq[1], b1.out_idx, b1.out_none);

    // Round-robin WIDTH=5, same request four times.
    idle(); iv[2] = 1; rq[2] = 8'b0001_0011;
    for (int k = 0; k < 4; k++) begin
      step("rr_seq");
      chk("rr_seq_idx", 2, 32'(b2.out_idx), 32'(rr_exp_idx[k]));
      chk("rr_seq_ptr", 2, 32'(dut_rr.g_rr.rr_ptr_q), 32'(rr_exp_ptr[k]));
      $display("rr req=%b idx=%0d ptr=%0d", rq[2][4:0], b2.out_idx, dut_rr.g_rr.rr_ptr_q);
    end

    // Backpressure: hold a result three cycles while another waits.
    idle(); iv[0] = 1; rq[0] = 8'b1001_0000; ordy[0] = 0;
    step("bp_load");
    rq[0] = 8'b0000_0110;
    for (int k = 0; k < 3; k++) begin
      step("bp_hold");
      chk("bp_hold_idx", 0, 32'(b0.out_idx), 32'd4);
      chk("bp_hold_ready", 0, 32'(b0.in_ready), 32'd0);
      $display("bp hold cycle=%0d idx=%0d in_ready=%0d", k, b0.out_idx, b0.in_ready);
    end
    ordy[0] = 1;
    step("bp_rel1");
    chk("bp_rel1_idx", 0, 32'(b0.out_idx), 32'd1);
    rq[0] = 8'b1000_0000;
    step("bp_rel2");
    chk("bp_rel2_idx", 0, 32'(b0.out_idx), 32'd7);
    iv[0] = 0;
    step("bp_drain");
    chk("bp_drain_valid", 0, 32'(b0.out_valid), 32'd0);
    $display("bp released, drained valid=%0d", b0.out_valid);

    // Async reset while a round-robin result is pending with rr_ptr=3.
    idle(); iv[2] = 1; rq[2] = 8'b0000_0100; ordy[2] = 0;
    step("rst_load");
    chk("rst_load_ptr", 2, 32'(dut_rr.g_rr.rr_ptr_q), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 2, 32'(b2.out_valid), 32'd0);
    chk("rst_async_ptr", 2, 32'(dut_rr.g_rr.rr_ptr_q), 32'd0);
    $display("async reset valid=%0d ptr=%0d", b2.out_valid, dut_rr.g_rr.rr_ptr_q);
    model_reset();
    idle();
    apply();
    @(negedge clk);
    rst_n = 1'b1;
    iv[2] = 1; rq[2] = 8'b0001_0011;
    step("rst_fresh");
    chk("rst_fresh_idx", 2, 32'(b2.out_idx), 32'd0);
    chk("rst_fresh_ptr", 2, 32'(dut_rr.g_rr.rr_ptr_q), 32'd1);

    // Multi-hot flag.
    idle(); iv[0] = 1; rq[0] = 8'b0001_0000;
    step("multi_one");
    chk("multi_one", 0, 32'(b0.out_multi), 32'd0);
    rq[0] = 8'b0001_0100;
    step("multi_two");
    chk("multi_two", 0, 32'(b0.out_multi), 32'(MULTI_EN));
    $display("multi req=%b out_multi=%0d", rq[0], b0.out_multi);

    // Random traffic with random consumer stalls on all three encoders.
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 3; d++) begin
        iv[d]   = ($urandom_range(0, 3) != 0);
        ordy[d] = ($urandom_range(0, 3) != 0);
        rq[d]   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
        if (d == 2) rq[d] = rq[d] & 8'h1F;
      end
      step("rand");
      if (n % 50 == 0)
        $display("rand n=%0d idx=%0d/%0d/%0d ptr=%0d", n, b0.out_idx, b1.out_idx, b2.out_idx, m_ptr[2]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_prio_encoder_pipe
